// File: rtl/gpio_func_sched_if.sv
// Request/busy/mapping bundle between gpio_func_sched and its client.
// master drives requests and busy flags; slave is the scheduler.
interface gpio_func_sched_if #(
  parameter int NUM_PINS = 8,
  parameter int PW = $clog2(NUM_PINS)
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic [PW-1:0]         i_req_pin;
  logic [1:0]            i_req_func;
  logic [3:0]            i_func_busy;
  logic [2*NUM_PINS-1:0] o_pin_sel;
  logic [NUM_PINS-1:0]   o_pin_park;
  logic                  o_done;
  logic                  o_err;

  modport master (
    output i_req_valid, i_req_pin, i_req_func, i_func_busy,
    input  o_req_ready, o_pin_sel, o_pin_park, o_done, o_err
  );

  modport slave (
    input  i_req_valid, i_req_pin, i_req_func, i_func_busy,
    output o_req_ready, o_pin_sel, o_pin_park, o_done, o_err
  );
endinterface

// File: rtl/gpio_func_sched.sv
// GPIO pin-function ownership scheduler: drain, park, commit.
// Optional drain timeout enabled by GPIO_FUNC_SCHED_TIMEOUT_EN.
module gpio_func_sched #(
  parameter int NUM_PINS      = 8,
  parameter int GUARD_CYCLES  = 4,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input logic               i_clk,
  input logic               i_reset,
  gpio_func_sched_if.slave  bus
);
  localparam int PW = $clog2(NUM_PINS);
  localparam int CW = $clog2(GUARD_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_PARK   = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic [1:0]            state;
  logic [PW-1:0]         pin_q;
  logic [1:0]            func_q;
  logic [1:0]            old_q;
  logic [PW-1:0]         vic_q;
  logic                  vic_v;
  logic [CW-1:0]         gcnt;
  logic [2*NUM_PINS-1:0] sel_q;
  logic                  done_q;
  logic                  err_q;

  logic                  pin_ok;
  logic [1:0]            cur_old;
  logic                  vic_hit;
  logic [PW-1:0]         vic_idx;
  logic                  drain_ok;

`ifdef GPIO_FUNC_SCHED_TIMEOUT_EN
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  logic [DW-1:0] dcnt;
`endif

  // Look up current owner of the requested pin and any victim pin
  always_comb begin
    pin_ok  = 1'b0;
    cur_old = 2'b00;
    vic_hit = 1'b0;
    vic_idx = '0;
    for (int k = 0; k < NUM_PINS; k++) begin
      if (bus.i_req_pin == PW'(k)) begin
        pin_ok  = 1'b1;
        cur_old = sel_q[2*k +: 2];
      end
      if (bus.i_req_func != 2'b00 &&
          sel_q[2*k +: 2] == bus.i_req_func &&
          bus.i_req_pin != PW'(k)) begin
        vic_hit = 1'b1;
        vic_idx = PW'(k);
      end
    end
  end

  assign drain_ok = !bus.i_func_busy[old_q] &&
                    (!vic_v || !bus.i_func_busy[func_q]);

  // Park the target pin and victim only while in PARK
  always_comb begin
    bus.o_pin_park = '0;
    for (int k = 0; k < NUM_PINS; k++) begin
      if (state == S_PARK &&
          (pin_q == PW'(k) || (vic_v && vic_q == PW'(k))))
        bus.o_pin_park[k] = 1'b1;
    end
  end

  // Request FSM, guard counter and pin mapping
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= S_IDLE;
      pin_q  <= '0;
      func_q <= 2'b00;
      old_q  <= 2'b00;
      vic_q  <= '0;
      vic_v  <= 1'b0;
      gcnt   <= '0;
      sel_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef GPIO_FUNC_SCHED_TIMEOUT_EN
      dcnt   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_req_valid) begin
            if (!pin_ok) begin
              err_q <= 1'b1;
            end else if (cur_old == bus.i_req_func) begin
              done_q <= 1'b1;
            end else begin
              pin_q  <= bus.i_req_pin;
              func_q <= bus.i_req_func;
              old_q  <= cur_old;
              vic_v  <= vic_hit;
              vic_q  <= vic_idx;
              state  <= S_DRAIN;
`ifdef GPIO_FUNC_SCHED_TIMEOUT_EN
              dcnt   <= '0;
`endif
            end
          end
        end
        S_DRAIN: begin
          if (drain_ok) begin
            gcnt  <= CW'(GUARD_CYCLES);
            state <= S_PARK;
          end
`ifdef GPIO_FUNC_SCHED_TIMEOUT_EN
          else if (dcnt == DW'(DRAIN_TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
`endif
        end
        S_PARK: begin
          if (gcnt == CW'(1))
            state <= S_COMMIT;
          else
            gcnt <= gcnt - CW'(1);
        end
        S_COMMIT: begin
          for (int k = 0; k < NUM_PINS; k++) begin
            if (pin_q == PW'(k))
              sel_q[2*k +: 2] <= func_q;
            else if (vic_v && vic_q == PW'(k))
              sel_q[2*k +: 2] <= 2'b00;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = (state == S_IDLE);
  assign bus.o_done      = done_q | (state == S_COMMIT);
  assign bus.o_err       = err_q;
  assign bus.o_pin_sel   = sel_q;
endmodule

// File: tb/tb_gpio_func_sched.sv
// Directed testbench for gpio_func_sched.
// Timeout scenario runs only with GPIO_FUNC_SCHED_TIMEOUT_EN.
module tb_gpio_func_sched;
  localparam int NP = 6;
  localparam int PW = $clog2(NP);
  localparam int G  = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  gpio_func_sched_if #(.NUM_PINS(NP)) bus ();

  gpio_func_sched #(
    .NUM_PINS(NP),
    .GUARD_CYCLES(G),
    .DRAIN_TIMEOUT(16)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int rlow, pcnt, pfirst, dn, dat, en, eat;
  logic [NP-1:0] pmask;

  task automatic do_req(
    input int pin, input int func,
    input logic [3:0] bz, input int bcyc, input int n
  );
    bus.i_func_busy = bz;
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_pin   = PW'(pin);
    bus.i_req_func  = 2'(func);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    bus.i_req_pin   = '0;
    bus.i_req_func  = 2'b00;
    rlow = 0; pcnt = 0; pfirst = -1;
    dn = 0; dat = -1; en = 0; eat = -1;
    pmask = '0;
    for (int i = 0; i < n; i++) begin
      if (i == bcyc) bus.i_func_busy = 4'b0000;
      if (!bus.o_req_ready) rlow++;
      if (bus.o_pin_park != '0) begin
        pcnt++;
        if (pfirst < 0) pfirst = i;
      end
      pmask = pmask | bus.o_pin_park;
      if (bus.o_done) begin
        dn++;
        if (dat < 0) dat = i;
      end
      if (bus.o_err) begin
        en++;
        if (eat < 0) eat = i;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (bus.o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=1", bus.o_req_ready);
    end
    checks++;
    if (bus.o_pin_sel !== 12'h000) begin
      errors++;
      $display("FAIL reset_sel got=%h exp=000", bus.o_pin_sel);
    end
    checks++;
    if (bus.o_pin_park !== 6'b0 || bus.o_done !== 1'b0 ||
        bus.o_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs park=%b done=%b err=%b exp 0",
               bus.o_pin_park, bus.o_done, bus.o_err);
    end
  endtask

  task automatic test_basic;
    do_req(3, 1, 4'b0000, 0, 12);
    checks++;
    if (rlow != 6) begin
      errors++;
      $display("FAIL t1_ready_low got=%0d exp=6", rlow);
    end
    checks++;
    if (pcnt != G || pmask !== 6'b001000 || pfirst != 1) begin
      errors++;
      $display("FAIL t1_park cnt=%0d mask=%b first=%0d exp 4 001000 1",
               pcnt, pmask, pfirst);
    end
    checks++;
    if (dn != 1 || dat != 5 || en != 0) begin
      errors++;
      $display("FAIL t1_done n=%0d at=%0d err=%0d exp 1 5 0",
               dn, dat, en);
    end
    checks++;
    if (bus.o_pin_sel !== 12'h040) begin
      errors++;
      $display("FAIL t1_sel got=%h exp=040", bus.o_pin_sel);
    end
  endtask

  task automatic test_victim;
    do_req(5, 1, 4'b0000, 0, 12);
    checks++;
    if (pmask !== 6'b101000 || pcnt != G) begin
      errors++;
      $display("FAIL t2_park mask=%b cnt=%0d exp 101000 4", pmask, pcnt);
    end
    checks++;
    if (bus.o_pin_sel !== 12'h400 || dn != 1) begin
      errors++;
      $display("FAIL t2_sel got=%h done=%0d exp 400 1",
               bus.o_pin_sel, dn);
    end
  endtask

  task automatic test_drain;
    do_req(2, 3, 4'b1000, 0, 12);
    checks++;
    if (bus.o_pin_sel !== 12'h430 || pmask !== 6'b000100 || rlow != 6) begin
      errors++;
      $display("FAIL t3_commit sel=%h mask=%b rlow=%0d exp 430 000100 6",
               bus.o_pin_sel, pmask, rlow);
    end
    do_req(2, 0, 4'b1000, 20, 40);
    checks++;
    if (pfirst != 21 || pcnt != G) begin
      errors++;
      $display("FAIL t3_park_wait first=%0d cnt=%0d exp 21 4",
               pfirst, pcnt);
    end
    checks++;
    if (dat != 25 || rlow != 26) begin
      errors++;
      $display("FAIL t3_latency done_at=%0d rlow=%0d exp 25 26",
               dat, rlow);
    end
    checks++;
    if (bus.o_pin_sel !== 12'h400) begin
      errors++;
      $display("FAIL t3_sel got=%h exp=400", bus.o_pin_sel);
    end
  endtask

  task automatic test_noop_badpin;
    do_req(5, 1, 4'b0000, 0, 6);
    checks++;
    if (dn != 1 || dat != 0 || pcnt != 0 || rlow != 0) begin
      errors++;
      $display("FAIL t5_noop done=%0d at=%0d park=%0d rlow=%0d exp 1 0 0 0",
               dn, dat, pcnt, rlow);
    end
    do_req(7, 2, 4'b0000, 0, 6);
    checks++;
    if (en != 1 || eat != 0 || dn != 0 || pcnt != 0) begin
      errors++;
      $display("FAIL t5_badpin err=%0d at=%0d done=%0d park=%0d exp 1 0 0 0",
               en, eat, dn, pcnt);
    end
    checks++;
    if (bus.o_pin_sel !== 12'h400) begin
      errors++;
      $display("FAIL t5_sel got=%h exp=400", bus.o_pin_sel);
    end
  endtask

  task automatic test_reset_mid;
    bus.i_func_busy = 4'b0000;
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_pin   = PW'(0);
    bus.i_req_func  = 2'd2;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_pin_park !== 6'b000001) begin
      errors++;
      $display("FAIL t6_in_park got=%b exp=000001", bus.o_pin_park);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_pin_park !== 6'b0 || bus.o_pin_sel !== 12'h000) begin
      errors++;
      $display("FAIL t6_async park=%b sel=%h exp 0 000",
               bus.o_pin_park, bus.o_pin_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_req_ready !== 1'b1 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL t6_after ready=%b done=%b exp 1 0",
               bus.o_req_ready, bus.o_done);
    end
  endtask

`ifdef GPIO_FUNC_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    do_req(1, 2, 4'b0001, 30, 40);
    checks++;
    if (en != 1 || eat != 16 || rlow != 16) begin
      errors++;
      $display("FAIL t4_timeout err=%0d at=%0d rlow=%0d exp 1 16 16",
               en, eat, rlow);
    end
    checks++;
    if (bus.o_pin_sel !== 12'h000 || pcnt != 0 || dn != 0) begin
      errors++;
      $display("FAIL t4_state sel=%h park=%0d done=%0d exp 000 0 0",
               bus.o_pin_sel, pcnt, dn);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.i_req_valid = 1'b0;
    bus.i_req_pin   = '0;
    bus.i_req_func  = 2'b00;
    bus.i_func_busy = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_basic;
    test_victim;
    test_drain;
    test_noop_badpin;
    test_reset_mid;
`ifdef GPIO_FUNC_SCHED_TIMEOUT_EN
    test_timeout;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
